shadow_chain_collector: RTL and testbench



---
 rtl/shadow_dbg_pkg.sv | 17 +
 rtl/shadow_word_fifo.sv | 55 +++++
 rtl/shadow_chain_collector.sv | 140 ++++++++++++++
 tb/tb_shadow_chain_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_dbg_pkg.sv
// Shared types and constants for the shadow-capture debug path.
// Used by the chain collector and its word FIFO.
package shadow_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DUMP,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam int WORD_W_DEF = 32;

   // Chain bit order as emitted by shadow_capture: first bit is word bit 0.
   localparam bit CHAIN_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shadow_word_fifo.sv
// First-word-fall-through word FIFO for the chain collector.
// A push while full is taken only if a pop happens in the same cycle.
module shadow_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rptr];

   // Storage array; no reset needed since empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/shadow_chain_collector.sv
// Requests a shadow dump, deserializes the chain into words
// and buffers them for a host reader.
module shadow_chain_collector
   import shadow_dbg_pkg::*;
#(
   parameter int WORD_W   = WORD_W_DEF,
   parameter int DEPTH    = 16,
   parameter int BITCNT_W = 16
) (
   input  logic                sh_clk,
   input  logic                sh_rst,
   input  logic                start,
   output logic                dump_en,
   input  logic                ch_in,
   input  logic                ch_in_vld,
   input  logic                ch_in_done,
   input  logic                rd_en,
   output logic [WORD_W-1:0]   rd_data,
   output logic                rd_vld,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [BITCNT_W-1:0] bit_count
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] sh_word;
   logic [WORD_W-1:0] word_nxt;
   logic [WORD_W-1:0] push_data;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  bit_pos;
   logic              start_ok;
   logic              take_bit;
   logic              word_full;
   logic              push;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;

   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
   assign take_bit  = (state == ST_DUMP) && ch_in_vld;
   assign word_full = take_bit && (idx == LAST_IDX);
   assign bit_pos   = CHAIN_LSB_FIRST ? idx : (LAST_IDX - idx);
   assign pop       = rd_en && !fifo_empty;
   assign drop      = push && fifo_full && !pop;
   assign busy      = (state == ST_DUMP) || (state == ST_FLUSH);
   assign done      = (state == ST_DONE);
   assign rd_vld    = !fifo_empty;

   // Shift register with the incoming bit merged in.
   always_comb begin
      word_nxt          = sh_word;
      word_nxt[bit_pos] = ch_in;
   end

   // Push a completed word, or the partial word left over in FLUSH.
   always_comb begin
      push      = 1'b0;
      push_data = word_nxt;
      if (word_full) begin
         push = 1'b1;
      end else if (state == ST_FLUSH && idx != '0) begin
         push      = 1'b1;
         push_data = sh_word;
      end
   end

   // Next-state logic for the dump sequence.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start) state_nxt = ST_DUMP;
         ST_DUMP:  if (ch_in_done) state_nxt = ST_FLUSH;
         ST_FLUSH: state_nxt = ST_DONE;
         ST_DONE:  if (start) state_nxt = ST_DUMP;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State and registered dump enable.
   always_ff @(posedge sh_clk or posedge sh_rst) begin
      if (sh_rst) begin
         state   <= ST_IDLE;
         dump_en <= 1'b0;
      end else begin
         state   <= state_nxt;
         dump_en <= (state_nxt == ST_DUMP);
      end
   end

   // Deserializer, bit counter and sticky overflow.
   always_ff @(posedge sh_clk or posedge sh_rst) begin
      if (sh_rst) begin
         sh_word   <= '0;
         idx       <= '0;
         bit_count <= '0;
         overflow  <= 1'b0;
      end else if (start_ok) begin
         sh_word   <= '0;
         idx       <= '0;
         bit_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (take_bit) begin
            if (!(&bit_count)) bit_count <= bit_count + BITCNT_W'(1);
            if (word_full) begin
               sh_word <= '0;
               idx     <= '0;
            end else begin
               sh_word <= word_nxt;
               idx     <= idx + IDX_W'(1);
            end
         end else if (state == ST_FLUSH) begin
            sh_word <= '0;
            idx     <= '0;
         end
         if (drop) overflow <= 1'b1;
      end
   end

   shadow_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (sh_clk),
      .rst       (sh_rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .rd_data   (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_shadow_chain_collector.sv
// Directed bench for shadow_chain_collector (WORD_W=32, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_shadow_chain_collector;

   logic        sh_clk = 1'b0;
   logic        sh_rst;
   logic        start;
   logic        dump_en;
   logic        ch_in;
   logic        ch_in_vld;
   logic        ch_in_done;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_vld;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [15:0] bit_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] ow [6];

   shadow_chain_collector #(
      .WORD_W   (32),
      .DEPTH    (4),
      .BITCNT_W (16)
   ) dut (
      .sh_clk     (sh_clk),
      .sh_rst     (sh_rst),
      .start      (start),
      .dump_en    (dump_en),
      .ch_in      (ch_in),
      .ch_in_vld  (ch_in_vld),
      .ch_in_done (ch_in_done),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_vld     (rd_vld),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .bit_count  (bit_count)
   );

   always #5 sh_clk = ~sh_clk;

   task automatic tick();
      @(posedge sh_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n,
                            input bit last_done);
      for (int i = 0; i < n; i++) begin
         ch_in      = w[i];
         ch_in_vld  = 1'b1;
         ch_in_done = last_done && (i == n - 1);
         tick();
      end
      ch_in      = 1'b0;
      ch_in_vld  = 1'b0;
      ch_in_done = 1'b0;
   endtask

   task automatic end_dump();
      ch_in_done = 1'b1;
      tick();
      ch_in_done = 1'b0;
      tick();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      sh_rst     = 1'b1;
      start      = 1'b0;
      ch_in      = 1'b0;
      ch_in_vld  = 1'b0;
      ch_in_done = 1'b0;
      rd_en      = 1'b0;
      for (int i = 0; i < 6; i++) ow[i] = 32'hA0B0_0000 + 32'(i * 32'h0101);

      // reset values
      tick();
      tick();
      chk("rst_dump_en", dump_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_bitcnt", bit_count, 0);
      chk("rst_rd_vld", rd_vld, 0);
      chk("rst_rd_data", rd_data, 0);
      sh_rst = 1'b0;
      tick();

      // chain activity in IDLE is ignored
      ch_in     = 1'b1;
      ch_in_vld = 1'b1;
      tick();
      tick();
      ch_in_vld = 1'b0;
      chk("idle_vld_bitcnt", bit_count, 0);
      chk("idle_vld_busy", busy, 0);
      chk("idle_vld_rd_vld", rd_vld, 0);

      // two full words
      do_start();
      chk("full_dump_en", dump_en, 1);
      chk("full_busy", busy, 1);
      send_bits(32'hDEAD_BEEF, 32, 1'b0);
      chk("full_first_vld", rd_vld, 1);
      send_bits(32'h1234_5678, 32, 1'b0);
      end_dump();
      chk("full_bitcnt", bit_count, 64);
      chk("full_done", done, 1);
      chk("full_dump_en_off", dump_en, 0);
      chk("full_ovf", overflow, 0);
      chk("full_w0", rd_data, 32'hDEAD_BEEF);
      pop();
      chk("full_w1", rd_data, 32'h1234_5678);
      pop();
      chk("full_empty_vld", rd_vld, 0);
      chk("full_empty_data", rd_data, 0);

      // partial word flushed
      do_start();
      send_bits(32'hCAFE_F00D, 32, 1'b0);
      send_bits(32'h0000_00A5, 8, 1'b0);
      ch_in_done = 1'b1;
      tick();
      ch_in_done = 1'b0;
      chk("part_flush_busy", busy, 1);
      chk("part_flush_dump_en", dump_en, 0);
      tick();
      chk("part_done", done, 1);
      chk("part_bitcnt", bit_count, 40);
      chk("part_w0", rd_data, 32'hCAFE_F00D);
      pop();
      chk("part_w1", rd_data, 32'h0000_00A5);
      pop();
      chk("part_empty", rd_vld, 0);

      // done with the last bit of a word
      do_start();
      send_bits(32'h0F0F_1234, 32, 1'b1);
      tick();
      chk("coinc_done", done, 1);
      chk("coinc_bitcnt", bit_count, 32);
      chk("coinc_w0", rd_data, 32'h0F0F_1234);
      pop();
      chk("coinc_no_extra", rd_vld, 0);

      // overflow with no reads
      do_start();
      for (int i = 0; i < 4; i++) send_bits(ow[i], 32, 1'b0);
      chk("ovf_four_ok", overflow, 0);
      send_bits(ow[4], 32, 1'b0);
      chk("ovf_set", overflow, 1);
      send_bits(ow[5], 32, 1'b0);
      end_dump();
      chk("ovf_sticky", overflow, 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_w%0d", i), rd_data, ow[i]);
         pop();
      end
      chk("ovf_empty", rd_vld, 0);

      // full FIFO with a pop in the push cycle
      do_start();
      chk("ovf2_cleared", overflow, 0);
      for (int i = 0; i < 4; i++) send_bits(ow[i], 32, 1'b0);
      send_bits(ow[4], 31, 1'b0);
      ch_in     = ow[4][31];
      ch_in_vld = 1'b1;
      rd_en     = 1'b1;
      tick();
      ch_in_vld = 1'b0;
      rd_en     = 1'b0;
      chk("ovf2_no_drop", overflow, 0);
      end_dump();
      chk("ovf2_no_drop_end", overflow, 0);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("ovf2_w%0d", i), rd_data, ow[i]);
         pop();
      end
      chk("ovf2_empty", rd_vld, 0);

      // asynchronous reset mid-dump
      do_start();
      send_bits(32'h1111_2222, 32, 1'b0);
      send_bits(32'h000F_FFFF, 20, 1'b0);
      chk("mrst_pre_bitcnt", bit_count, 52);
      chk("mrst_pre_vld", rd_vld, 1);
      #2;
      sh_rst = 1'b1;
      #1;
      chk("mrst_dump_en", dump_en, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_bitcnt", bit_count, 0);
      chk("mrst_rd_vld", rd_vld, 0);
      chk("mrst_rd_data", rd_data, 0);
      tick();
      sh_rst = 1'b0;
      tick();
      chk("mrst_idle", busy, 0);
      do_start();
      send_bits(32'h55AA_1234, 32, 1'b0);
      end_dump();
      chk("mrst_run_done", done, 1);
      chk("mrst_run_bitcnt", bit_count, 32);
      chk("mrst_run_w0", rd_data, 32'h55AA_1234);

      // chain activity in DONE is ignored
      ch_in      = 1'b1;
      ch_in_vld  = 1'b1;
      ch_in_done = 1'b1;
      tick();
      tick();
      ch_in_vld  = 1'b0;
      ch_in_done = 1'b0;
      chk("done_vld_bitcnt", bit_count, 32);
      chk("done_vld_done", done, 1);
      pop();
      chk("done_vld_empty", rd_vld, 0);

      // read while empty is ignored
      pop();
      chk("empty_rd_vld", rd_vld, 0);
      chk("empty_rd_data", rd_data, 0);

      // start during DUMP is ignored
      do_start();
      send_bits(32'h0000_03FF, 10, 1'b0);
      start     = 1'b1;
      ch_in     = 1'b1;
      ch_in_vld = 1'b1;
      tick();
      start     = 1'b0;
      ch_in_vld = 1'b0;
      chk("dump_start_busy", busy, 1);
      chk("dump_start_bitcnt", bit_count, 11);
      end_dump();
      chk("dump_start_done", done, 1);
      chk("dump_start_w0", rd_data, 32'h0000_07FF);
      pop();
      chk("dump_start_empty", rd_vld, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
